// File: rtl/seg_scan_display.sv
// seg_scan_display: binary score to 4-digit common-anode seven-segment display.
// A sequential double-dabble engine converts the (saturated) score to BCD,
// leading zeros are blanked, digits are time-multiplexed at a fixed scan rate
// and the whole display blinks while gameover is high.
//
// Converter FSM states:
//   state   | meaning
//   S_IDLE  | waiting for the saturated input to differ from last_value
//   S_SHIFT | 16 add-3/shift steps, one binary bit per cycle
//   S_DONE  | copy finished BCD into the display digit registers
module seg_scan_display #(
  parameter int CLK_HZ   = 100_000_000,
  parameter int SCAN_HZ  = 1000,
  parameter int BLINK_HZ = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] seg_value,
  input  logic        gameover,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int DWELL   = CLK_HZ / SCAN_HZ;
  localparam int HALF    = CLK_HZ / (2 * BLINK_HZ);
  localparam int TICK_W  = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int BLINK_W = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(DWELL - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(HALF - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]         state;
  logic [15:0]        last_value;
  logic [15:0]        sat_value;
  logic [15:0]        bin_sr;
  logic [15:0]        bcd;
  logic [15:0]        bcd_adj;
  logic [31:0]        dd_shift;
  logic [3:0]         shift_cnt;
  logic [15:0]        digits;      // d3..d0 packed, d0 in [3:0]

  logic [TICK_W-1:0]  tick_cnt;
  logic [1:0]         scan_idx;

  logic [BLINK_W-1:0] blink_cnt;
  logic               phase_on;
  logic               gameover_d;

  logic [3:0]         blank;
  logic [3:0]         cur_digit;
  logic               cur_blank;
  logic [6:0]         cur_seg;

  // Values above the 4-digit range display as 9999.
  assign sat_value = (seg_value > 16'd9999) ? 16'd9999 : seg_value;

  // Add-3 correction on every BCD nibble that is 5 or more.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < 4; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
    end
  end

  // Shifting the joined {bcd, binary} word moves the next binary MSB into BCD.
  assign dd_shift = {bcd_adj, bin_sr} << 1;

  // Converter: capture on change, 16 shift steps, then publish to digits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      last_value <= '0;
      bin_sr     <= '0;
      bcd        <= '0;
      shift_cnt  <= '0;
      digits     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (sat_value != last_value) begin
            bin_sr     <= sat_value;
            last_value <= sat_value;
            bcd        <= '0;
            shift_cnt  <= '0;
            state      <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          bcd       <= dd_shift[31:16];
          bin_sr    <= dd_shift[15:0];
          shift_cnt <= shift_cnt + 4'd1;
          if (shift_cnt == 4'd15) begin
            state <= S_DONE;
          end
        end
        S_DONE: begin
          digits <= bcd;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Scan timer: dwell on each digit, then advance the digit index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
      scan_idx <= '0;
    end else if (tick_cnt == TICK_LAST) begin
      tick_cnt <= '0;
      scan_idx <= scan_idx + 2'd1;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  // Blink timer: restarts in the on-phase on each gameover rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt  <= '0;
      phase_on   <= 1'b1;
      gameover_d <= 1'b0;
    end else begin
      gameover_d <= gameover;
      if (!gameover || !gameover_d) begin
        blink_cnt <= '0;
        phase_on  <= 1'b1;
      end else if (blink_cnt == BLINK_LAST) begin
        blink_cnt <= '0;
        phase_on  <= ~phase_on;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  // Leading-zero blanking; the units digit always shows.
  always_comb begin
    blank    = 4'b0000;
    blank[3] = (digits[15:12] == 4'd0);
    blank[2] = blank[3] && (digits[11:8] == 4'd0);
    blank[1] = blank[2] && (digits[7:4] == 4'd0);
  end

  // Select the digit for the current scan slot and decode it (active-low gfedcba).
  always_comb begin
    cur_digit = digits[3:0];
    cur_blank = blank[0];
    case (scan_idx)
      2'd1: begin cur_digit = digits[7:4];   cur_blank = blank[1]; end
      2'd2: begin cur_digit = digits[11:8];  cur_blank = blank[2]; end
      2'd3: begin cur_digit = digits[15:12]; cur_blank = blank[3]; end
      default: begin cur_digit = digits[3:0]; cur_blank = blank[0]; end
    endcase
    case (cur_digit)
      4'd0:    cur_seg = 7'b1000000;
      4'd1:    cur_seg = 7'b1111001;
      4'd2:    cur_seg = 7'b0100100;
      4'd3:    cur_seg = 7'b0110000;
      4'd4:    cur_seg = 7'b0011001;
      4'd5:    cur_seg = 7'b0010010;
      4'd6:    cur_seg = 7'b0000010;
      4'd7:    cur_seg = 7'b1111000;
      4'd8:    cur_seg = 7'b0000000;
      4'd9:    cur_seg = 7'b0010000;
      default: cur_seg = 7'b1111111;
    endcase
  end

  // Registered outputs so an and seg always switch on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an  <= 4'b1111;
      seg <= 7'b1111111;
    end else begin
      an  <= phase_on ? ~(4'b0001 << scan_idx) : 4'b1111;
      seg <= cur_blank ? 7'b1111111 : cur_seg;
    end
  end

  assign dp = 1'b1;

endmodule
